phase_ramp_gen_v4: RTL and testbench
====================================

// Module: phase_ramp_gen_v4
// PURPOSE
//  Closed-loop FOG serrodyne generator, successor to the v3 ladder: parametrised width, explicit 2pi wrap against a runtime V2pi.
//  Adds a programmable mod-alignment delay and a saturated, registered phase-ramp output.
//  Sits between the loop filter (step source) and the DAC driver.
//  Emits wrap pulses used by the rate/angle integrator.
// PARAMETERS
//  OUTPUT_BIT    16  DAC word width (signed) for ladder, mod and ramp
//  MOD_DLY        1  i_mod register stages before summing, 0..8
//  WRAP_CNT_BIT  24  width of optional signed wrap counter
// PORTS
//  i_clk       in   1              system clock
//  i_rst_n     in   1              async active-low reset
//  i_trig      in   1              one-cycle step strobe (one per eigen period)
//  i_step      in   OUTPUT_BIT     signed ladder step, DAC LSB
//  i_fb_on     in   1              1 = closed loop running, 0 = ladder forced to 0
//  i_mod       in   OUTPUT_BIT     signed bias-modulation word
//  i_v2pi      in   OUTPUT_BIT+1   unsigned 2pi span in LSB; bit0 ignored
//  o_ladderWave out OUTPUT_BIT     registered wrapped ladder
//  o_phaseRamp  out OUTPUT_BIT     registered sat(ladder + delayed mod)
//  o_wrap_p     out 1              1-cycle pulse, positive 2pi reset
//  o_wrap_n     out 1              1-cycle pulse, negative 2pi reset
//  o_wrap_cnt   out WRAP_CNT_BIT   signed net wrap count (see CONFIGURATION)
// BEHAVIOUR
//  Reset (async, i_rst_n=0):
//   - All outputs 0, mod pipe 0, state OFF.
//   - v2pi_q = 2^OUTPUT_BIT.
//  FSM, 2 states:
//   - OFF: ladder<=0, wrap pulses 0. v2pi_q<=i_v2pi every cycle, bit0 cleared.
//     Values <4 or >2^OUTPUT_BIT load 2^OUTPUT_BIT.
//   - OFF->RUN on i_fb_on=1. A trig in that same cycle is ignored.
//   - RUN: v2pi_q frozen; i_v2pi changes take effect only after a return to OFF.
//   - RUN->OFF on i_fb_on=0. Ladder is 0 on the next edge, any same-cycle trig is discarded.
//  Step path (RUN, i_trig=1):
//   - half = v2pi_q>>1; stepc = i_step clamped to [-(half-1), half-1].
//   - sum = ladder + stepc, computed OUTPUT_BIT+2 wide; no intermediate overflow.
//   - If sum >= half: ladder <= sum - v2pi_q, o_wrap_p=1.
//   - Else if sum < -half: ladder <= sum + v2pi_q, o_wrap_n=1.
//   - Else ladder <= sum.
//   - Clamp guarantees at most one wrap per trig; ladder always stays in [-half, half-1].
//  RUN, i_trig=0: ladder holds; wrap pulses 0.
//  Latency:
//   - trig@N -> o_ladderWave and wrap pulse valid after edge N+1.
//   - o_phaseRamp valid after edge N+2.
//  Mod path:
//   - mod_d = i_mod through MOD_DLY registers; MOD_DLY=0 is a pass-through.
//   - Mod is summed in both OFF and RUN; OFF outputs pure modulation.
//  o_phaseRamp <= sat(ladder + mod_d), evaluated OUTPUT_BIT+1 wide.
//   - Saturates to +2^(OUTPUT_BIT-1)-1 / -2^(OUTPUT_BIT-1); never wraps.
//  Full-scale mapping: 32767 = +Vpi, -32768 = -Vpi at OUTPUT_BIT=16, v2pi=65536.
// CONFIGURATION
//  Macro PR_WRAP_CNT_EN.
//  Defined:
//   - o_wrap_cnt +1 on o_wrap_p, -1 on o_wrap_n, updated same edge as the pulse.
//   - Saturates at the signed WRAP_CNT_BIT limits.
//   - Cleared to 0 in OFF and on reset.
//  Undefined: o_wrap_cnt tied to 0, no counter logic.
// TESTING
//  1 Reset mid-RUN, ladder=12000 -> all outputs 0 asynchronously; v2pi_q=65536 after release.
//  2 v2pi=65536, step=1000, trig every 4 clk from 0 -> ladder 1000,2000,...,32000.
//    Next trig -> -32536 with o_wrap_p 1 cycle; cnt=1 if PR_WRAP_CNT_EN.
//  3 step=-3000, ladder=-32000 -> -35000 < -32768 -> ladder=30536, o_wrap_n; cnt decrements.
//  4 step=40000-equivalent clamp: v2pi=20000, step=+9999 ok, step=+15000 -> clamped to 9999.
//  5 ladder=32000, i_mod=+2000, MOD_DLY=1 -> o_phaseRamp=32767 (saturated), 2 clk after mod change.
//  6 fb_on 1->0 with trig same cycle -> ladder 0 next edge, no wrap pulse.
//    i_v2pi changed during RUN -> ignored until OFF.

Source files
------------

// File: rtl/phase_ramp_gen_v4.sv
// phase_ramp_gen_v4 : closed-loop FOG serrodyne ladder with 2pi wrap against a
// runtime V2pi, delayed bias-modulation sum and saturated phase-ramp output.
// Optional feature macro: PR_WRAP_CNT_EN (signed saturating net wrap counter).
module phase_ramp_gen_v4 #(
   parameter int OUTPUT_BIT   = 16,
   parameter int MOD_DLY      = 1,
   parameter int WRAP_CNT_BIT = 24
) (
   input  logic                           i_clk,
   input  logic                           i_rst_n,
   input  logic                           i_trig,
   input  logic signed [OUTPUT_BIT-1:0]   i_step,
   input  logic                           i_fb_on,
   input  logic signed [OUTPUT_BIT-1:0]   i_mod,
   input  logic        [OUTPUT_BIT:0]     i_v2pi,
   output logic signed [OUTPUT_BIT-1:0]   o_ladderWave,
   output logic signed [OUTPUT_BIT-1:0]   o_phaseRamp,
   output logic                           o_wrap_p,
   output logic                           o_wrap_n,
   output logic signed [WRAP_CNT_BIT-1:0] o_wrap_cnt
);

   localparam int W  = OUTPUT_BIT;
   localparam int SW = OUTPUT_BIT + 2;

   localparam logic        [W:0]    V2PI_FULL = {1'b1, {W{1'b0}}};
   localparam logic        [W:0]    V2PI_MIN  = {{(W-2){1'b0}}, 3'b100};
   localparam logic signed [SW-1:0] ONE_S     = {{(SW-1){1'b0}}, 1'b1};
   localparam logic signed [W:0]    PR_MAX    = {2'b00, {(W-1){1'b1}}};
   localparam logic signed [W:0]    PR_MIN    = {2'b11, {(W-1){1'b0}}};

   typedef enum logic {ST_OFF = 1'b0, ST_RUN = 1'b1} state_t;

   state_t                r_state;
   logic        [W:0]     r_v2pi;
   logic signed [W-1:0]   r_ladder;
   logic signed [W-1:0]   r_phase_ramp;
   logic                  r_wrap_p;
   logic                  r_wrap_n;

   logic        [W:0]     w_v2pi_in;
   logic        [W:0]     w_v2pi_ld;
   logic signed [SW-1:0]  w_v2pi_ext;
   logic signed [SW-1:0]  w_half;
   logic signed [SW-1:0]  w_lim;
   logic signed [SW-1:0]  w_step_ext;
   logic signed [SW-1:0]  w_stepc;
   logic signed [SW-1:0]  w_sum;
   logic signed [W-1:0]   w_step_ladder;
   logic                  w_step_wrap_p;
   logic                  w_step_wrap_n;
   logic signed [W-1:0]   w_mod_d;
   logic signed [W:0]     w_pr_sum;
   logic signed [W-1:0]   w_pr_sat;

   // Qualify the incoming 2pi span: clear bit0, replace out-of-range values by full scale.
   always_comb begin
      w_v2pi_in = i_v2pi & ~{{W{1'b0}}, 1'b1};
      if ((w_v2pi_in < V2PI_MIN) || (w_v2pi_in > V2PI_FULL)) begin
         w_v2pi_ld = V2PI_FULL;
      end else begin
         w_v2pi_ld = w_v2pi_in;
      end
   end

   // Step path: clamp step to +-(half-1), add wide, wrap once by the frozen 2pi span.
   always_comb begin
      w_v2pi_ext    = signed'({1'b0, r_v2pi});
      w_half        = signed'({1'b0, r_v2pi} >> 1);
      w_lim         = w_half - ONE_S;
      w_step_ext    = {{2{i_step[W-1]}}, i_step};
      if (w_step_ext > w_lim) begin
         w_stepc = w_lim;
      end else if (w_step_ext < -w_lim) begin
         w_stepc = -w_lim;
      end else begin
         w_stepc = w_step_ext;
      end
      w_sum         = {{2{r_ladder[W-1]}}, r_ladder} + w_stepc;
      w_step_wrap_p = 1'b0;
      w_step_wrap_n = 1'b0;
      if (w_sum >= w_half) begin
         w_step_ladder = W'(w_sum - w_v2pi_ext);
         w_step_wrap_p = 1'b1;
      end else if (w_sum < -w_half) begin
         w_step_ladder = W'(w_sum + w_v2pi_ext);
         w_step_wrap_n = 1'b1;
      end else begin
         w_step_ladder = W'(w_sum);
      end
   end

   // Control FSM: OFF tracks V2pi and forces the ladder to 0, RUN applies triggered steps.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state  <= ST_OFF;
         r_v2pi   <= V2PI_FULL;
         r_ladder <= {W{1'b0}};
         r_wrap_p <= 1'b0;
         r_wrap_n <= 1'b0;
      end else begin
         case (r_state)
            ST_OFF: begin
               r_ladder <= {W{1'b0}};
               r_wrap_p <= 1'b0;
               r_wrap_n <= 1'b0;
               r_v2pi   <= w_v2pi_ld;
               if (i_fb_on) begin
                  r_state <= ST_RUN;
               end else begin
                  r_state <= ST_OFF;
               end
            end
            ST_RUN: begin
               if (!i_fb_on) begin
                  r_state  <= ST_OFF;
                  r_ladder <= {W{1'b0}};
                  r_wrap_p <= 1'b0;
                  r_wrap_n <= 1'b0;
               end else if (i_trig) begin
                  r_ladder <= w_step_ladder;
                  r_wrap_p <= w_step_wrap_p;
                  r_wrap_n <= w_step_wrap_n;
               end else begin
                  r_wrap_p <= 1'b0;
                  r_wrap_n <= 1'b0;
               end
            end
            default: begin
               r_state  <= ST_OFF;
               r_ladder <= {W{1'b0}};
               r_wrap_p <= 1'b0;
               r_wrap_n <= 1'b0;
            end
         endcase
      end
   end

   // Modulation alignment delay line (pure wire when no stages are requested).
   generate
      if (MOD_DLY == 0) begin : g_mod_nodly
         assign w_mod_d = i_mod;
      end else begin : g_mod_dly
         logic signed [W-1:0] r_mod_pipe [MOD_DLY];
         // Shift the modulation word through MOD_DLY registers.
         always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
               for (int i = 0; i < MOD_DLY; i++) begin
                  r_mod_pipe[i] <= {W{1'b0}};
               end
            end else begin
               r_mod_pipe[0] <= i_mod;
               for (int i = 1; i < MOD_DLY; i++) begin
                  r_mod_pipe[i] <= r_mod_pipe[i-1];
               end
            end
         end
         assign w_mod_d = r_mod_pipe[MOD_DLY-1];
      end
   endgenerate

   // Saturating sum of ladder and delayed modulation; the DAC word must never wrap.
   always_comb begin
      w_pr_sum = {r_ladder[W-1], r_ladder} + {w_mod_d[W-1], w_mod_d};
      if (w_pr_sum > PR_MAX) begin
         w_pr_sat = W'(PR_MAX);
      end else if (w_pr_sum < PR_MIN) begin
         w_pr_sat = W'(PR_MIN);
      end else begin
         w_pr_sat = W'(w_pr_sum);
      end
   end

   // Register the phase-ramp output.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_phase_ramp <= {W{1'b0}};
      end else begin
         r_phase_ramp <= w_pr_sat;
      end
   end

`ifdef PR_WRAP_CNT_EN
   localparam logic signed [WRAP_CNT_BIT-1:0] CNT_MAX = {1'b0, {(WRAP_CNT_BIT-1){1'b1}}};
   localparam logic signed [WRAP_CNT_BIT-1:0] CNT_MIN = {1'b1, {(WRAP_CNT_BIT-1){1'b0}}};
   localparam logic signed [WRAP_CNT_BIT-1:0] CNT_ONE = {{(WRAP_CNT_BIT-1){1'b0}}, 1'b1};
   logic signed [WRAP_CNT_BIT-1:0] r_wrap_cnt;

   // Net wrap counter, moving on the same edge as the wrap pulse; held at 0 outside RUN.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wrap_cnt <= {WRAP_CNT_BIT{1'b0}};
      end else if ((r_state != ST_RUN) || !i_fb_on) begin
         r_wrap_cnt <= {WRAP_CNT_BIT{1'b0}};
      end else if (i_trig && w_step_wrap_p && (r_wrap_cnt != CNT_MAX)) begin
         r_wrap_cnt <= r_wrap_cnt + CNT_ONE;
      end else if (i_trig && w_step_wrap_n && (r_wrap_cnt != CNT_MIN)) begin
         r_wrap_cnt <= r_wrap_cnt - CNT_ONE;
      end else begin
         r_wrap_cnt <= r_wrap_cnt;
      end
   end
   assign o_wrap_cnt = r_wrap_cnt;
`else
   assign o_wrap_cnt = {WRAP_CNT_BIT{1'b0}};
`endif

   assign o_ladderWave = r_ladder;
   assign o_phaseRamp  = r_phase_ramp;
   assign o_wrap_p     = r_wrap_p;
   assign o_wrap_n     = r_wrap_n;

endmodule

// File: tb/tb_phase_ramp_gen_v4.sv
// Directed bench for phase_ramp_gen_v4 (OUTPUT_BIT=16, MOD_DLY=1, WRAP_CNT_BIT=24).
module tb_phase_ramp_gen_v4;

   localparam int CNT_EN =
`ifdef PR_WRAP_CNT_EN
      1;
`else
      0;
`endif

   logic               clk;
   logic               rst_n;
   logic               trig;
   logic signed [15:0] step;
   logic               fb_on;
   logic signed [15:0] mod;
   logic        [16:0] v2pi;
   logic signed [15:0] ladder;
   logic signed [15:0] pramp;
   logic               wrap_p;
   logic               wrap_n;
   logic signed [23:0] wcnt;

   int n_pass  = 0;
   int n_total = 0;

   phase_ramp_gen_v4 #(.OUTPUT_BIT(16), .MOD_DLY(1), .WRAP_CNT_BIT(24)) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_trig       (trig),
      .i_step       (step),
      .i_fb_on      (fb_on),
      .i_mod        (mod),
      .i_v2pi       (v2pi),
      .o_ladderWave (ladder),
      .o_phaseRamp  (pramp),
      .o_wrap_p     (wrap_p),
      .o_wrap_n     (wrap_n),
      .o_wrap_cnt   (wcnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic do_trig(input logic signed [15:0] s);
      step = s;
      trig = 1'b1;
      tick();
      trig = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; trig = 1'b0; step = 16'sd0; fb_on = 1'b0; mod = 16'sd0; v2pi = 17'd65536;
      #12;
      chk("rst_ladder", ladder, 0);
      chk("rst_pramp", pramp, 0);
      chk("rst_wrap_p", {31'd0, wrap_p}, 0);
      chk("rst_wcnt", wcnt, 0);
      tick();
      rst_n = 1'b1;
      tick(); tick();

      // enter RUN, climb the ladder by 1000 per trigger
      fb_on = 1'b1;
      tick();
      chk("run_entry_ladder", ladder, 0);
      for (int k = 1; k <= 32; k++) begin
         do_trig(16'sd1000);
         chk("ramp_ladder", ladder, k * 1000);
         chk("ramp_pramp_lat", pramp, (k - 1) * 1000);
         chk("ramp_no_wrap", {31'd0, wrap_p}, 0);
         tick(); tick(); tick();
      end
      chk("ramp_pramp_32000", pramp, 32000);

      // positive wrap
      do_trig(16'sd1000);
      chk("wrap_p_ladder", ladder, -32536);
      chk("wrap_p_pulse", {31'd0, wrap_p}, 1);
      chk("wrap_p_no_n", {31'd0, wrap_n}, 0);
      chk("wrap_p_cnt", wcnt, CNT_EN);
      tick();
      chk("wrap_p_one_cycle", {31'd0, wrap_p}, 0);

      // negative wrap
      do_trig(16'sd536);
      chk("pre_neg_ladder", ladder, -32000);
      do_trig(-16'sd3000);
      chk("wrap_n_ladder", ladder, 30536);
      chk("wrap_n_pulse", {31'd0, wrap_n}, 1);
      chk("wrap_n_cnt", wcnt, 0);
      tick();
      chk("wrap_n_one_cycle", {31'd0, wrap_n}, 0);

      // modulation saturation, two clocks after the mod change
      do_trig(16'sd1464);
      chk("pre_mod_ladder", ladder, 32000);
      tick();
      mod = 16'sd2000;
      tick();
      chk("mod_dly_1clk", pramp, 32000);
      tick();
      chk("mod_sat_pos", pramp, 32767);
      mod = -16'sd2000;
      tick(); tick();
      chk("mod_neg_sum", pramp, 30000);
      mod = 16'sd0;
      tick(); tick();

      // V2pi change during RUN is ignored
      v2pi = 17'd20000;
      tick();
      do_trig(16'sd1000);
      chk("v2pi_frozen_ladder", ladder, -32536);
      chk("v2pi_frozen_wrap", {31'd0, wrap_p}, 1);
      chk("v2pi_frozen_cnt", wcnt, CNT_EN);

      // fb_on drop with simultaneous trigger
      fb_on = 1'b0;
      do_trig(16'sd1000);
      chk("off_ladder_zero", ladder, 0);
      chk("off_no_wrap", {31'd0, wrap_p}, 0);
      tick();
      chk("off_cnt_clear", wcnt, 0);
      mod = -16'sd1234;
      tick(); tick();
      chk("off_pure_mod", pramp, -1234);
      mod = 16'sd0;

      // re-enter RUN with trigger ignored, now V2pi=20000 -> clamp 9999
      fb_on = 1'b1;
      do_trig(16'sd5000);
      chk("entry_trig_ignored", ladder, 0);
      do_trig(16'sd9999);
      chk("clamp_9999_ok", ladder, 9999);
      chk("clamp_9999_nowrap", {31'd0, wrap_p}, 0);
      do_trig(16'sd15000);
      chk("clamp_pos_ladder", ladder, -2);
      chk("clamp_pos_wrap", {31'd0, wrap_p}, 1);
      chk("clamp_pos_cnt", wcnt, CNT_EN);
      do_trig(-16'sd15000);
      chk("clamp_neg_ladder", ladder, 9999);
      chk("clamp_neg_wrap", {31'd0, wrap_n}, 1);
      chk("clamp_neg_cnt", wcnt, 0);

      // invalid V2pi loads full scale
      fb_on = 1'b0;
      v2pi = 17'd2;
      tick(); tick();
      fb_on = 1'b1;
      tick();
      do_trig(16'sd32767);
      chk("v2pi_invalid_full", ladder, 32767);
      chk("v2pi_invalid_nowrap", {31'd0, wrap_p}, 0);

      // asynchronous reset mid-RUN at ladder=12000
      do_trig(-16'sd20767);
      chk("pre_rst_ladder", ladder, 12000);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_ladder", ladder, 0);
      chk("arst_pramp", pramp, 0);
      chk("arst_wrap_p", {31'd0, wrap_p}, 0);
      chk("arst_wrap_n", {31'd0, wrap_n}, 0);
      chk("arst_wcnt", wcnt, 0);
      #3;
      v2pi = 17'd65536;
      rst_n = 1'b1;
      tick();
      do_trig(16'sd1000);
      chk("post_rst_ladder", ladder, 1000);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
